serial_alu: RTL and testbench
=============================

# serial_alu

Parametrised bit-serial ALU: processes two WIDTH-bit operands one bit per clock, LSB first, with carry/borrow chained through a single full-adder slice. It takes a start/done handshake and updates the result and all flags atomically on completion. It generalises the 4-bit fixed-phase serial ALU to any width and adds signed overflow, logic ops and a compare op. It sits between the operand register file and the result/flag registers of the datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2–32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A; latched on accepted start.
- B  in  WIDTH  operand B; latched on accepted start.
- opcode  in  3  operation; latched on accepted start.
- abort  in  1  cancel the current operation; present only with SERIAL_ALU_ABORT_EN.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- C  out  WIDTH  result.
- carr  out  1  carry-out (ADD) or borrow-out (SUB/CMP).
- sign  out  1  C[WIDTH-1] of the committed result.
- zero  out  1  committed result == 0.
- ovf  out  1  signed overflow (ADD/SUB/CMP).

## Operation
- Opcodes:
  - 000 CLR: C=0, carr=0, sign=0, zero=1, ovf=0.
  - 001 XNOR.
  - 010 SUB, computed as B−A.
  - 011 NAND.
  - 100 ADD, computed as A+B.
  - 101 XOR.
  - 110 OR.
  - 111 CMP: flags as SUB, C keeps its previous value.
- States:
  - IDLE: start=1 latches A, B and opcode. Goes to CLR if opcode=000, otherwise to RUN with bit counter=0, carry-in=0 (ADD) or borrow-in=0 (SUB/CMP).
  - RUN: one bit per edge into a result shift register. Carry/borrow and the zero accumulator update each edge. After bit WIDTH-1, commits outputs and returns to IDLE.
  - CLR: commits the CLR values and returns to IDLE.
- Arithmetic: SUB result is raw two's complement mod 2^WIDTH; no magnitude conversion.
- Flags:
  - carr=1 for SUB/CMP when A>B unsigned.
  - ovf for ADD: operands have the same sign and the result sign differs.
  - ovf for SUB/CMP: B and A have different signs and the result sign differs from B's sign.
  - Logic ops: carr=0, ovf=0.
- Commit: C (except CMP), carr, sign, zero and ovf change only on the commit edge. They hold between operations.
- A start while busy=1 is ignored. Operands and opcode changing during RUN have no effect.

## Timing
- Accepted start at edge N:
  - busy=1 from edge N.
  - Arithmetic/logic ops commit at edge N+WIDTH: done=1 and busy=0 for the cycle after that edge.
  - CLR commits at edge N+1.
- done is high exactly one cycle. A start sampled while done=1 is accepted (back-to-back, no bubble).
- Reset values: C=0, carr=0, sign=0, zero=1, ovf=0, busy=0, done=0, state IDLE.
- rst asserted mid-operation: outputs take reset values immediately, with no done pulse. Operation restarts only on a new start after rst deasserts.

## Configuration
- SERIAL_ALU_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in RUN or CLR returns the block to IDLE at the next edge, with no done and no output change.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- SERIAL_ALU_ABORT_EN undefined: the abort port and its logic are absent, and every accepted operation runs to completion.

## Test plan
All scenarios use WIDTH=8.
- ADD A=8'h7F, B=8'h01 → C=8'h80, carr=0, sign=1, zero=0, ovf=1. done exactly 8 cycles after the start edge, busy high for those 8 cycles.
- SUB A=8'h05, B=8'h03 → C=8'hFE, carr=1, sign=1, ovf=0. SUB A=B=8'h3C → C=0, zero=1, carr=0.
- NAND A=B=8'hFF → C=0, zero=1, carr=0, ovf=0. XNOR A=B=8'h0F → C=8'hFF, sign=1.
- CMP A=8'h10, B=8'h20 after a prior result C=8'h55 → C stays 8'h55, carr=0, zero=0, ovf=0. Then CLR → C=0, zero=1, done 1 cycle after start.
- start with different operands while busy → ignored, first result committed. start in the done cycle → accepted, second done 8 cycles later.
- rst pulsed at RUN bit 3 → outputs at reset values asynchronously, no done. With SERIAL_ALU_ABORT_EN, abort at bit 3 → busy=0 next edge, outputs unchanged, no done.

Source files
------------

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU, LSB first, one full-adder slice, start/done handshake.
// Optional abort port and logic enabled by defining SERIAL_ALU_ABORT_EN.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             carr,
  output logic             sign,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_XNOR = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLR} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_cy;
  logic             r_nz;

  logic             w_a;
  logic             w_b;
  logic             w_bit;
  logic             w_cy_n;
  logic             w_arith;
  logic             w_sub;
  logic             w_ovf;
  logic             w_last;
  logic             w_abort;
  logic [WIDTH-1:0] w_res_n;

  assign w_a     = r_a[0];
  assign w_b     = r_b[0];
  assign w_sub   = (r_op == OP_SUB) || (r_op == OP_CMP);
  assign w_arith = w_sub || (r_op == OP_ADD);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_res_n = {w_bit, r_res[WIDTH-1:1]};

`ifdef SERIAL_ALU_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Subtraction is B-A, so the borrow is generated when A's bit exceeds B's.
  always_comb begin
    w_bit  = 1'b0;
    w_cy_n = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_bit  = w_a ^ w_b ^ r_cy;
        w_cy_n = (w_a & w_b) | (r_cy & (w_a ^ w_b));
      end
      OP_SUB, OP_CMP: begin
        w_bit  = w_a ^ w_b ^ r_cy;
        w_cy_n = (w_a & ~w_b) | (r_cy & ~(w_a ^ w_b));
      end
      OP_XNOR: w_bit = ~(w_a ^ w_b);
      OP_NAND: w_bit = ~(w_a & w_b);
      OP_XOR:  w_bit = w_a ^ w_b;
      OP_OR:   w_bit = w_a | w_b;
      default: w_bit = 1'b0;
    endcase
  end

  // On the last bit r_a[0]/r_b[0] hold the operand sign bits.
  always_comb begin
    w_ovf = 1'b0;
    if (r_op == OP_ADD)
      w_ovf = (w_a == w_b) && (w_bit != w_a);
    else if (w_sub)
      w_ovf = (w_a != w_b) && (w_bit != w_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= OP_CLR;
      r_cnt   <= '0;
      r_cy    <= 1'b0;
      r_nz    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      C       <= '0;
      carr    <= 1'b0;
      sign    <= 1'b0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= opcode;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_nz    <= 1'b0;
            busy    <= 1'b1;
            r_state <= (opcode == OP_CLR) ? S_CLR : S_RUN;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= w_res_n;
            r_cy  <= w_cy_n;
            r_nz  <= r_nz | w_bit;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              if (r_op != OP_CMP)
                C <= w_res_n;
              carr    <= w_arith ? w_cy_n : 1'b0;
              sign    <= w_bit;
              zero    <= ~(r_nz | w_bit);
              ovf     <= w_ovf;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_CLR: begin
          if (!w_abort) begin
            C    <= '0;
            carr <= 1'b0;
            sign <= 1'b0;
            zero <= 1'b1;
            ovf  <= 1'b0;
            done <= 1'b1;
          end
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - table-driven self-checking bench for serial_alu (WIDTH=8).
module tb_serial_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] opcode = '0;
  logic       abort = 1'b0;
  logic       busy, done, carr, sign, zero, ovf;
  logic [7:0] C;

  int n_pass = 0;
  int n_total = 0;

  serial_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .opcode(opcode),
`ifdef SERIAL_ALU_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .C(C), .carr(carr), .sign(sign), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [3:0] f;
    int         lat;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic do_start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    A = a; B = b; opcode = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b; opcode = op ^ 3'b111;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic no_done_for(input int n, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk(name, seen, 1'b0);
  endtask

  initial begin
    int lat;
    bit bok;
    logic [7:0] c_hold;

    //            op      a      b      c      {carr,sign,zero,ovf} lat
    vt[0]  = '{3'b100, 8'h7F, 8'h01, 8'h80, 4'b0101, 8};
    vt[1]  = '{3'b010, 8'h05, 8'h03, 8'hFE, 4'b1100, 8};
    vt[2]  = '{3'b010, 8'h3C, 8'h3C, 8'h00, 4'b0010, 8};
    vt[3]  = '{3'b011, 8'hFF, 8'hFF, 8'h00, 4'b0010, 8};
    vt[4]  = '{3'b001, 8'h0F, 8'h0F, 8'hFF, 4'b0100, 8};
    vt[5]  = '{3'b101, 8'hF0, 8'hA5, 8'h55, 4'b0000, 8};
    vt[6]  = '{3'b111, 8'h10, 8'h20, 8'h55, 4'b0000, 8};
    vt[7]  = '{3'b000, 8'h33, 8'h44, 8'h00, 4'b0010, 1};
    vt[8]  = '{3'b100, 8'hFF, 8'h01, 8'h00, 4'b1010, 8};
    vt[9]  = '{3'b110, 8'h12, 8'h40, 8'h52, 4'b0000, 8};
    vt[10] = '{3'b010, 8'h01, 8'h80, 8'h7F, 4'b0001, 8};
    vt[11] = '{3'b100, 8'h80, 8'h80, 8'h00, 4'b1011, 8};
    vt[12] = '{3'b111, 8'hFF, 8'h00, 8'h00, 4'b1000, 8};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_C", C, 8'h00);
    chk("reset_flags", {carr, sign, zero, ovf}, 4'b0010);
    chk("reset_busy_done", {busy, done}, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      do_start(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_busy_after_start", i), busy, 1'b1);
      wait_done(lat, bok);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_busy_during", i), bok, 1'b1);
      chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      chk($sformatf("v%0d_C", i), C, vt[i].c);
      chk($sformatf("v%0d_flags", i), {carr, sign, zero, ovf}, vt[i].f);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), done, 1'b0);
    end

    // start while busy is ignored; start in the done cycle is accepted
    do_start(3'b100, 8'h01, 8'h02);
    @(posedge clk); #1;
    do_start(3'b100, 8'h10, 8'h20);
    wait_done(lat, bok);
    chk("busy_start_latency", lat, 6);
    chk("busy_start_ignored_C", C, 8'h03);
    do_start(3'b100, 8'h04, 8'h05);
    chk("b2b_busy", busy, 1'b1);
    wait_done(lat, bok);
    chk("b2b_latency", lat, 8);
    chk("b2b_C", C, 8'h09);
    @(posedge clk); #1;

    // asynchronous reset in the middle of RUN
    do_start(3'b100, 8'h7F, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_C", C, 8'h00);
    chk("midrst_flags", {carr, sign, zero, ovf}, 4'b0010);
    chk("midrst_busy_done", {busy, done}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    no_done_for(12, "midrst_no_done");
    chk("midrst_idle_busy", busy, 1'b0);

`ifdef SERIAL_ALU_ABORT_EN
    do_start(3'b101, 8'h0F, 8'hF0);
    wait_done(lat, bok);
    chk("pre_abort_C", C, 8'hFF);
    @(posedge clk); #1;
    c_hold = C;
    do_start(3'b100, 8'h01, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    no_done_for(12, "abort_no_done");
    chk("abort_C_held", C, c_hold);
    chk("abort_flags_held", {carr, sign, zero, ovf}, 4'b0100);
`else
    c_hold = C;
    chk("idle_C_hold", c_hold, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
